// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, ALU codes and FSM states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b110010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MUL_WAIT,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type funct to ALU operation decoder; purely combinational, zero latency, no handshake.
module alu_op_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          funct,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                legal,
  output logic                is_mul
);

  always_comb begin
    alu_op = '0;
    legal  = 1'b1;
    is_mul = 1'b0;
    case (funct)
      FN_ADD: alu_op = ALU_OP_W'(ALU_ADD);
      FN_SUB: alu_op = ALU_OP_W'(ALU_SUB);
      FN_AND: alu_op = ALU_OP_W'(ALU_AND);
      FN_OR:  alu_op = ALU_OP_W'(ALU_OR);
      FN_MUL: begin
        alu_op = ALU_OP_W'(ALU_MUL);
        is_mul = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM, one instruction in flight; accept->done 2 (beq) to MUL_LAT+2 (mul), plus memory wait.
// Backpressure: instr_ready only in IDLE (never in TRAP); MEM holds its strobe until mem_ack.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int MUL_LAT  = 4,
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                mem_ack,
  input  logic                alu_zero,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                branch,
  output logic                pc_write,
  output logic                done,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  localparam int MUL_CW = $clog2(MUL_LAT + 1);
  localparam bit MUL_WAIT_EN = (MUL_LAT > 1);
  localparam logic [MUL_CW-1:0] MUL_LOAD = MUL_CW'(MUL_WAIT_EN ? MUL_LAT - 2 : 0);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [MUL_CW-1:0]   mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                ready_q, ready_d;
  logic                reg_write_q, reg_write_d;
  logic                reg_dst_q, reg_dst_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                alu_src_q, alu_src_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic                branch_q, branch_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;

  logic [5:0]          opcode;
  logic                is_r, is_lw, is_sw, is_beq;
  logic                fn_legal, fn_mul, op_legal, accept;
  logic [ALU_OP_W-1:0] fn_alu_op;
  logic                unused_ir;

  assign opcode   = ir_q[INSTR_W-1 -: 6];
  assign is_r     = (opcode == OP_RTYPE);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign op_legal = (is_r & fn_legal) | is_lw | is_sw | is_beq;
  assign accept   = instr_valid & ready_q;
  // Register/immediate fields of the IR feed the datapath, not this controller.
  assign unused_ir = ^ir_q[INSTR_W-7:6];

  alu_op_decoder #(.ALU_OP_W(ALU_OP_W)) u_alu_op_decoder (
    .funct  (ir_q[5:0]),
    .alu_op (fn_alu_op),
    .legal  (fn_legal),
    .is_mul (fn_mul)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = op_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (is_r) begin
          if (fn_mul && MUL_WAIT_EN) begin
            state_d   = ST_MUL_WAIT;
            mul_cnt_d = MUL_LOAD;
          end else begin
            state_d = ST_WB;
          end
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL_WAIT: begin
        if (mul_cnt_q == '0) state_d = ST_WB;
        else                 mul_cnt_d = mul_cnt_q - MUL_CW'(1);
      end
      ST_MEM: begin
        if (mem_ack) state_d = is_lw ? ST_WB : ST_IDLE;
      end
      ST_WB:   state_d = ST_IDLE;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are the decode of the next state, so they appear registered in that state's cycle.
  always_comb begin
    ready_d      = (state_d == ST_IDLE);
    reg_write_d  = (state_d == ST_WB);
    reg_dst_d    = (state_d == ST_WB) & is_r;
    mem_to_reg_d = (state_d == ST_WB) & is_lw;
    mem_read_d   = (state_d == ST_MEM) & is_lw;
    mem_write_d  = (state_d == ST_MEM) & is_sw;
    alu_src_d    = ((state_d == ST_EXEC) || (state_d == ST_MEM)) & (is_lw | is_sw);
    branch_d     = (state_d == ST_EXEC) & is_beq;
    illegal_d    = (state_d == ST_TRAP);
    alu_op_d     = '0;
    if (state_d == ST_EXEC) begin
      if (is_r)        alu_op_d = fn_alu_op;
      else if (is_beq) alu_op_d = ALU_OP_W'(ALU_SUB);
      else             alu_op_d = ALU_OP_W'(ALU_ADD);
    end else if (state_d == ST_MUL_WAIT) begin
      alu_op_d = ALU_OP_W'(ALU_MUL);
    end
    done_d    = (state_d == ST_IDLE) &&
                ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB));
    retired_d = retired_q + CNT_W'(done_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ir_q         <= '0;
      mul_cnt_q    <= '0;
      retired_q    <= '0;
      ready_q      <= 1'b1;
      reg_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      alu_op_q     <= '0;
      branch_q     <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      mul_cnt_q    <= mul_cnt_d;
      retired_q    <= retired_d;
      ready_q      <= ready_d;
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      alu_op_q     <= alu_op_d;
      branch_q     <= branch_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
    end
  end

  assign instr_ready = ready_q;
  assign ir_write    = accept;
  assign reg_write   = reg_write_q;
  assign reg_dst     = reg_dst_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign alu_src     = alu_src_q;
  assign alu_op      = alu_op_q;
  assign branch      = branch_q;
  // The ALU flag is only meaningful while EXEC computes the compare.
  assign pc_write    = branch_q & alu_zero;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table, corner sequences and randomized traffic against a reference model.
module tb_multicycle_control;

  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid, mem_ack, alu_zero;

  logic        instr_ready, ir_write, reg_write, reg_dst, mem_to_reg, mem_read, mem_write;
  logic        alu_src, branch, pc_write, done, illegal;
  logic [3:0]  alu_op;
  logic [15:0] retired;

  logic        m1_instr_ready, m1_ir_write, m1_reg_write, m1_reg_dst, m1_mem_to_reg, m1_mem_read;
  logic        m1_mem_write, m1_alu_src, m1_branch, m1_pc_write, m1_done, m1_illegal;
  logic [3:0]  m1_alu_op;
  logic [15:0] m1_retired;

  logic        c2_instr_ready, c2_ir_write, c2_reg_write, c2_reg_dst, c2_mem_to_reg, c2_mem_read;
  logic        c2_mem_write, c2_alu_src, c2_branch, c2_pc_write, c2_done, c2_illegal;
  logic [3:0]  c2_alu_op;
  logic [1:0]  c2_retired;

  logic [14:0] all_outs;
  assign all_outs = {ir_write, reg_write, reg_dst, mem_to_reg, mem_read, mem_write,
                     alu_src, alu_op, branch, pc_write, done, illegal};

  always #5 clk = ~clk;

  multicycle_control #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .mem_ack(mem_ack), .alu_zero(alu_zero), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .pc_write(pc_write), .done(done),
    .illegal(illegal), .retired(retired)
  );

  multicycle_control #(.MUL_LAT(1)) dut_m1 (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(m1_instr_ready),
    .mem_ack(mem_ack), .alu_zero(alu_zero), .ir_write(m1_ir_write), .reg_write(m1_reg_write),
    .reg_dst(m1_reg_dst), .mem_to_reg(m1_mem_to_reg), .mem_read(m1_mem_read),
    .mem_write(m1_mem_write), .alu_src(m1_alu_src), .alu_op(m1_alu_op), .branch(m1_branch),
    .pc_write(m1_pc_write), .done(m1_done), .illegal(m1_illegal), .retired(m1_retired)
  );

  multicycle_control #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(c2_instr_ready),
    .mem_ack(mem_ack), .alu_zero(alu_zero), .ir_write(c2_ir_write), .reg_write(c2_reg_write),
    .reg_dst(c2_reg_dst), .mem_to_reg(c2_mem_to_reg), .mem_read(c2_mem_read),
    .mem_write(c2_mem_write), .alu_src(c2_alu_src), .alu_op(c2_alu_op), .branch(c2_branch),
    .pc_write(c2_pc_write), .done(c2_done), .illegal(c2_illegal), .retired(c2_retired)
  );

  typedef struct {
    logic [31:0] instr;
    int          n_ack;
    bit          zero;
    int          lat;
    logic [3:0]  op;
    bit          src;
    int          rd;
    int          wr;
    int          rw;
    bit          dst;
    bit          m2r;
    bit          pcw;
    int          mulc;
  } vec_t;

  typedef struct {
    int         lat;
    logic [3:0] op;
    bit         src;
    int         rd;
    int         wr;
    int         rw;
    bit         dst;
    bit         m2r;
    bit         pcw;
    int         mulc;
    bit         irw;
    bit         busy_rdy;
  } obs_t;

  int n_chk = 0;
  int n_fail = 0;
  int exp_ret;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: expected behaviour of one instruction from the opcode/funct rules.
  function automatic vec_t model(input logic [31:0] ins, input int n, input bit z);
    vec_t e;
    e = '{default: 0};
    e.instr = ins; e.n_ack = n; e.zero = z;
    case (ins[31:26])
      6'b000001: begin
        e.rw = 1; e.dst = 1; e.lat = 3;
        case (ins[5:0])
          6'b100000: e.op = 4'b0010;
          6'b100010: e.op = 4'b0110;
          6'b100100: e.op = 4'b0000;
          6'b100101: e.op = 4'b0001;
          6'b110010: begin e.op = 4'b1000; e.lat = MUL_LAT + 2; e.mulc = MUL_LAT; end
          default: e.lat = -1;
        endcase
      end
      6'b000010: begin e.lat = 3 + n; e.op = 4'b0010; e.src = 1; e.rd = n; e.rw = 1; e.m2r = 1; end
      6'b000011: begin e.lat = 2 + n; e.op = 4'b0010; e.src = 1; e.wr = n; end
      6'b000100: begin e.lat = 2; e.op = 4'b0110; e.pcw = z; end
      default:   e.lat = -1;
    endcase
    return e;
  endfunction

  task automatic reset_all();
    rst = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0; instr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the done edge.
  task automatic run_instr(input logic [31:0] ins, input int n_ack, input bit zero, output obs_t o);
    int memc;
    o = '{default: 0};
    o.lat = -1;
    memc = 0;
    alu_zero = zero; instr = ins; instr_valid = 1'b1;
    #1 o.irw = ir_write;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (instr_ready) o.busy_rdy = 1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        o.lat = k; instr_valid = 1'b0; mem_ack = 1'b0;
        break;
      end
      if (instr_ready) o.busy_rdy = 1;
      if (k == 1) begin o.op = alu_op; o.src = alu_src; o.pcw = pc_write; end
      if (alu_op == 4'b1000) o.mulc++;
      if (mem_read) o.rd++;
      if (mem_write) o.wr++;
      if (reg_write) begin o.rw++; o.dst = reg_dst; o.m2r = mem_to_reg; end
      if (mem_read || mem_write) begin
        memc++;
        mem_ack = (memc == n_ack);
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      // Illegal junk offered while busy must never be latched.
      instr = 32'hFC00_0000;
      instr_valid = 1'($urandom_range(0, 1));
    end
    mem_ack = 1'b0; instr_valid = 1'b0;
  endtask

  task automatic cmp_obs(input string tag, input vec_t e, input obs_t o);
    check({tag, ".lat"}, o.lat, e.lat);
    check({tag, ".alu_op"}, int'(o.op), int'(e.op));
    check({tag, ".alu_src"}, int'(o.src), int'(e.src));
    check({tag, ".rd_cyc"}, o.rd, e.rd);
    check({tag, ".wr_cyc"}, o.wr, e.wr);
    check({tag, ".rw_cyc"}, o.rw, e.rw);
    check({tag, ".reg_dst"}, int'(o.dst), int'(e.dst));
    check({tag, ".mem_to_reg"}, int'(o.m2r), int'(e.m2r));
    check({tag, ".pc_write"}, int'(o.pcw), int'(e.pcw));
    check({tag, ".mul_cyc"}, o.mulc, e.mulc);
    check({tag, ".ir_write"}, int'(o.irw), 1);
    check({tag, ".ready_busy"}, int'(o.busy_rdy), 0);
    if (o.lat > 0) exp_ret++;
    check({tag, ".retired"}, int'(retired), exp_ret & 16'hFFFF);
    check({tag, ".retired_w2"}, int'(c2_retired), exp_ret & 3);
  endtask

  task automatic accept_only(input logic [31:0] ins);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  vec_t tbl[10];
  obs_t o;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [3:0] op_seen;
    logic rw_seen;
    logic [5:0] fns[5];

    tbl[0] = '{32'h0422_4820, 1, 0, 3, 4'b0010, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{32'h0422_4822, 1, 0, 3, 4'b0110, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[2] = '{32'h0422_4824, 1, 0, 3, 4'b0000, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[3] = '{32'h0422_4825, 1, 0, 3, 4'b0001, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[4] = '{32'h0422_4032, 1, 0, 6, 4'b1000, 0, 0, 0, 1, 1, 0, 0, 4};
    tbl[5] = '{32'h0CCA_0000, 3, 0, 5, 4'b0010, 1, 0, 3, 0, 0, 0, 0, 0};
    tbl[6] = '{32'h0862_0004, 1, 0, 4, 4'b0010, 1, 1, 0, 1, 0, 1, 0, 0};
    tbl[7] = '{32'h0862_0008, 4, 0, 7, 4'b0010, 1, 4, 0, 1, 0, 1, 0, 0};
    tbl[8] = '{32'h1022_0003, 1, 1, 2, 4'b0110, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[9] = '{32'h1022_0003, 1, 0, 2, 4'b0110, 0, 0, 0, 0, 0, 0, 0, 0};

    reset_all();
    check("reset.outs", int'(all_outs), 0);
    check("reset.ready", int'(instr_ready), 1);
    check("reset.retired", int'(retired), 0);

    exp_ret = 0;
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].instr, tbl[i].n_ack, tbl[i].zero, o);
      cmp_obs($sformatf("tbl%0d", i), tbl[i], o);
    end

    // Single-cycle multiplier skips MUL_WAIT entirely.
    reset_all();
    accept_only(32'h0422_4032);
    cnt = -1; op_seen = '0; rw_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 1) op_seen = m1_alu_op;
      if (k == 2) rw_seen = m1_reg_write;
      if (m1_done) begin cnt = k; break; end
    end
    check("mul_lat1.lat", cnt, 3);
    check("mul_lat1.alu_op", int'(op_seen), 8);
    check("mul_lat1.wb", int'(rw_seen), 1);

    // Illegal opcode traps until reset.
    reset_all();
    accept_only(32'hFC00_0000);
    @(posedge clk); #1;
    check("trap.ready_e1", int'(instr_ready), 0);
    @(posedge clk); #1;
    check("trap.illegal_e2", int'(illegal), 1);
    check("trap.ready_e2", int'(instr_ready), 0);
    instr = 32'h0422_4820; instr_valid = 1'b1; cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done || ir_write) cnt++;
    end
    instr_valid = 1'b0;
    check("trap.no_accept", cnt, 0);
    check("trap.sticky", int'(illegal), 1);
    check("trap.retired", int'(retired), 0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("trap.rst_illegal", int'(illegal), 0);
    check("trap.rst_ready", int'(instr_ready), 1);

    // Illegal funct under a legal R-type opcode.
    accept_only(32'h0422_403F);
    @(posedge clk); #1; @(posedge clk); #1;
    check("trap_fn.illegal", int'(illegal), 1);

    // Reset mid MUL_WAIT.
    reset_all();
    accept_only(32'h0422_4032);
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1 check("rst_mul.in_wait", int'(alu_op), 8);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("rst_mul.outs", int'(all_outs), 0);
    check("rst_mul.ready", int'(instr_ready), 1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; if (done) cnt++; end
    check("rst_mul.no_done", cnt, 0);

    // Reset mid MEM with no ack ever arriving.
    accept_only(32'h0CCA_0000);
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1 check("rst_mem.strobe", int'(mem_write), 1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check("rst_mem.outs", int'(all_outs), 0);
    check("rst_mem.retired", int'(retired), 0);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (done) cnt++; end
    check("rst_mem.no_done", cnt, 0);

    // Narrow counter wraps after 4 retirements.
    reset_all();
    exp_ret = 0;
    for (int i = 0; i < 5; i++) begin
      run_instr(32'h0422_4820, 1, 0, o);
      if (o.lat > 0) exp_ret++;
    end
    check("wrap.retired_w2", int'(c2_retired), 1);
    check("wrap.retired", int'(retired), 5);

    // Randomized legal traffic against the model.
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b110010;
    reset_all();
    exp_ret = 0;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ins;
      int n;
      bit z;
      vec_t e;
      n = $urandom_range(1, 5);
      z = 1'($urandom_range(0, 1));
      ins = $urandom;
      case ($urandom_range(0, 3))
        0: begin ins[31:26] = 6'b000001; ins[5:0] = fns[$urandom_range(0, 4)]; end
        1: ins[31:26] = 6'b000010;
        2: ins[31:26] = 6'b000011;
        default: ins[31:26] = 6'b000100;
      endcase
      e = model(ins, n, z);
      run_instr(ins, n, z, o);
      cmp_obs($sformatf("rnd%0d", i), e, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
